// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch address, reads program bytes over a req/ack
// handshake into a small prefetch FIFO and presents the head byte to the controller.
module fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_i,
    input  logic        pc_load_i,
    input  logic [15:0] pc_in_i,
    output logic [7:0]  instr_o,
    output logic        instr_valid_o,
    output logic [15:0] pc_o,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_data_i
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDrop} state_e;

    state_e          state_q, state_d;
    logic [15:0]     fetch_pc_q, fetch_pc_d;
    logic            mem_req_q, mem_req_d;
    logic [15:0]     mem_addr_q, mem_addr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] wr_idx;
    logic [7:0]      buf_data_q [DEPTH];
    logic [7:0]      buf_data_d [DEPTH];
    logic [15:0]     buf_addr_q [DEPTH];
    logic [15:0]     buf_addr_d [DEPTH];
    logic [7:0]      instr_q, instr_d;
    logic [15:0]     pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            ack, push, pop, issue_ok;

    // Acks that arrive with no request outstanding are ignored.
    assign ack  = mem_ack_i & mem_req_q;
    assign pop  = fetch_i & valid_q;
    assign push = ack & (state_q == StBusy) & ~pc_load_i;

    // Shift-register FIFO: entry 0 is always the head.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_addr_d = buf_addr_q;
        count_d    = count_q;
        wr_idx     = count_q - CntW'(pop);
        if (pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                buf_data_d[i] = buf_data_q[i+1];
                buf_addr_d[i] = buf_addr_q[i+1];
            end
        end
        if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CntW'(i) == wr_idx) begin
                    buf_data_d[i] = mem_data_i;
                    buf_addr_d[i] = mem_addr_q;
                end
            end
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
        if (pc_load_i) begin
            count_d = '0;
        end
    end

    // Head registers keep their last value once the FIFO drains.
    always_comb begin
        valid_d = (count_d != '0);
        instr_d = valid_d ? buf_data_d[0] : instr_q;
        pc_d    = valid_d ? buf_addr_d[0] : pc_q;
    end

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        issue_ok   = (count_d < CntW'(DEPTH));
        if (pc_load_i) begin
            fetch_pc_d = pc_in_i;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 16'd1;
        end
        // A new request is registered as soon as one may be issued, so it is visible next cycle.
        case (state_q)
            StIdle: begin
                if (issue_ok) begin
                    state_d    = StBusy;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_d;
                end
            end
            StBusy: begin
                if (pc_load_i && !ack) begin
                    state_d = StDrop;
                end else if (ack) begin
                    if (issue_ok) begin
                        mem_addr_d = fetch_pc_d;
                    end else begin
                        state_d   = StIdle;
                        mem_req_d = 1'b0;
                    end
                end
            end
            StDrop: begin
                if (ack) begin
                    if (issue_ok) begin
                        state_d    = StBusy;
                        mem_addr_d = fetch_pc_d;
                    end else begin
                        state_d   = StIdle;
                        mem_req_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            count_q    <= '0;
            instr_q    <= 8'h00;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= 8'h00;
                buf_addr_q[i] <= 16'h0000;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            buf_data_q <= buf_data_d;
            buf_addr_q <= buf_addr_d;
        end
    end

    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc_q;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a responder memory returns addr[7:0] after a set wait.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        fetch;
    logic        pc_load;
    logic [15:0] pc_in;
    logic [7:0]  instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;

    int n_cmp    = 0;
    int n_fail   = 0;
    int mem_wait = 0;
    int wait_cnt = 0;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .fetch_i      (fetch),
        .pc_load_i    (pc_load),
        .pc_in_i      (pc_in),
        .instr_o      (instr),
        .instr_valid_o(instr_valid),
        .pc_o         (pc),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_ack_i    (mem_ack),
        .mem_data_i   (mem_data)
    );

    always #5 clk = ~clk;

    // Memory: acks after mem_wait idle cycles of a held request, data = addr[7:0].
    always @(negedge clk) begin
        if (mem_req !== 1'b1) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= mem_wait) begin
            mem_ack  = 1'b1;
            mem_data = mem_addr[7:0];
            wait_cnt = 0;
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = wait_cnt + 1;
        end
    end

    // A push must never land on a full FIFO.
    always @(posedge clk) begin
        if (rst_ni === 1'b1 && dut.push === 1'b1) begin
            n_cmp++;
            if (int'(dut.count_q) >= int'(DEPTH)) begin
                n_fail++;
                $display("FAIL push_full: count %0d, must be below %0d", dut.count_q, DEPTH);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int w, input logic f, input logic pl, input logic [15:0] pin);
        rst_ni   = 1'b0;
        fetch    = f;
        pc_load  = pl;
        pc_in    = pin;
        mem_wait = w;
        repeat (2) @(posedge clk);
        #3;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        fetch    = 1'b0;
        pc_load  = 1'b0;
        pc_in    = 16'h0000;
        mem_wait = 0;
        rst_ni   = 1'b1;
        #1 rst_ni = 1'b0;
        #2;
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", mem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 8'h00) begin n_fail++; $display("FAIL rst_instr: got %h want 00", instr); end
        n_cmp++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", pc); end
        @(posedge clk);
        #3 rst_ni = 1'b1;
        step();
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", mem_req); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL first_addr: got %h want 0000", mem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid: got %b want 0", instr_valid); end
    endtask

    task automatic test_stream();
        logic [15:0] ea;
        logic [15:0] ep;
        do_reset(0, 1'b1, 1'b0, 16'h0000);
        for (int k = 1; k <= 8; k++) begin
            step();
            ea = 16'(k - 1);
            ep = 16'(k - 2);
            n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req k=%0d: got %b want 1", k, mem_req); end
            n_cmp++; if (mem_addr !== ea) begin n_fail++; $display("FAIL stream_addr k=%0d: got %h want %h", k, mem_addr, ea); end
            if (k >= 2) begin
                n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid k=%0d: got %b want 1", k, instr_valid); end
                n_cmp++; if (instr !== ep[7:0]) begin n_fail++; $display("FAIL stream_instr k=%0d: got %h want %h", k, instr, ep[7:0]); end
                n_cmp++; if (pc !== ep) begin n_fail++; $display("FAIL stream_pc k=%0d: got %h want %h", k, pc, ep); end
            end
        end
    endtask

    task automatic test_fill_stall();
        do_reset(0, 1'b0, 1'b0, 16'h0000);
        step();
        step();
        n_cmp++; if (mem_addr !== 16'h0001) begin n_fail++; $display("FAIL fill_addr1: got %h want 0001", mem_addr); end
        step();
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fill_req_off: got %b want 0", mem_req); end
        n_cmp++; if (instr !== 8'h00 || pc !== 16'h0000) begin n_fail++; $display("FAIL fill_head: got %h/%h want 00/0000", instr, pc); end
        step();
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fill_req_stay: got %b want 0", mem_req); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %b want 1", instr_valid); end
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin n_fail++; $display("FAIL pop_req: got %b/%h want 1/0002", mem_req, mem_addr); end
        n_cmp++; if (instr !== 8'h01 || pc !== 16'h0001) begin n_fail++; $display("FAIL pop_head: got %h/%h want 01/0001", instr, pc); end
        step();
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL refill_req: got %b want 0", mem_req); end
        n_cmp++; if (instr !== 8'h01 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL refill_head: got %h/%b want 01/1", instr, instr_valid); end
    endtask

    task automatic test_wait();
        do_reset(3, 1'b1, 1'b0, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL wait_hold0 k=%0d: got %b/%h want 1/0000", k, mem_req, mem_addr); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_empty k=%0d: got %b want 0", k, instr_valid); end
        end
        fetch = 1'b0;
        step();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 8'h00 || pc !== 16'h0000) begin n_fail++; $display("FAIL wait_first: got %b/%h/%h want 1/00/0000", instr_valid, instr, pc); end
        for (int k = 5; k <= 8; k++) begin
            if (k > 5) step();
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin n_fail++; $display("FAIL wait_hold1 k=%0d: got %b/%h want 1/0001", k, mem_req, mem_addr); end
        end
        step();
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL wait_full: got %b want 0", mem_req); end
        n_cmp++; if (instr !== 8'h00 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_head: got %h/%b want 00/1", instr, instr_valid); end
    endtask

    task automatic test_drop();
        do_reset(3, 1'b1, 1'b0, 16'h0000);
        repeat (21) step();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0005) begin n_fail++; $display("FAIL drop_pre: got %b/%h want 1/0005", mem_req, mem_addr); end
        pc_load = 1'b1;
        pc_in   = 16'h1234;
        step();
        pc_load = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL drop_flush: got %b want 0", instr_valid); end
        for (int k = 22; k <= 24; k++) begin
            if (k > 22) step();
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0005) begin n_fail++; $display("FAIL drop_hold k=%0d: got %b/%h want 1/0005", k, mem_req, mem_addr); end
        end
        step();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h1234) begin n_fail++; $display("FAIL drop_new: got %b/%h want 1/1234", mem_req, mem_addr); end
        for (int k = 25; k <= 28; k++) begin
            if (k > 25) step();
            n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL drop_discard k=%0d: got %b want 0", k, instr_valid); end
        end
        step();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 8'h34 || pc !== 16'h1234) begin n_fail++; $display("FAIL drop_target: got %b/%h/%h want 1/34/1234", instr_valid, instr, pc); end
    endtask

    task automatic test_wrap();
        logic [15:0] ep;
        logic [15:0] ea;
        do_reset(0, 1'b1, 1'b1, 16'hFFFE);
        step();
        pc_load = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_start: got %b/%h want 1/fffe", mem_req, mem_addr); end
        for (int k = 2; k <= 5; k++) begin
            step();
            ep = 16'hFFFE + 16'(k - 2);
            ea = ep + 16'd1;
            n_cmp++; if (mem_addr !== ea) begin n_fail++; $display("FAIL wrap_addr k=%0d: got %h want %h", k, mem_addr, ea); end
            n_cmp++; if (instr_valid !== 1'b1 || pc !== ep || instr !== ep[7:0]) begin n_fail++; $display("FAIL wrap_head k=%0d: got %b/%h/%h want 1/%h/%h", k, instr_valid, pc, instr, ep, ep[7:0]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(0, 1'b0, 1'b0, 16'h0000);
        step();
        step();
        n_cmp++; if (mem_req !== 1'b1 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b/%b want 1/1", mem_req, instr_valid); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async: got %b/%b want 0/0", mem_req, instr_valid); end
        n_cmp++; if (mem_addr !== 16'h0000 || instr !== 8'h00) begin n_fail++; $display("FAIL mid_vals: got %h/%h want 0000/00", mem_addr, instr); end
        #2 rst_ni = 1'b1;
        step();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL mid_restart: got %b/%h want 1/0000", mem_req, mem_addr); end
        step();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 8'h00 || pc !== 16'h0000) begin n_fail++; $display("FAIL mid_first: got %b/%h/%h want 1/00/0000", instr_valid, instr, pc); end
    endtask

    initial begin
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        test_reset();
        test_stream();
        test_fill_stall();
        test_wait();
        test_drop();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
